// File: rtl/qar_input_capture.sv
// rtl/qar_input_capture.sv - QAR timer input capture: pin sync, edge detect, prescaled timestamp FIFO, MMIO, IRQ
module qar_input_capture #(
  parameter int CNT_W      = 32,
  parameter int FIFO_DEPTH = 4,
  parameter int PRESC_W    = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_valid,
  input  logic        mem_we,
  input  logic [4:0]  mem_addr,
  input  logic [31:0] mem_wdata,
  output logic        mem_ready,
  output logic [31:0] mem_rdata,
  input  logic        cap_in,
  output logic        irq
);
  localparam int AW = $clog2(FIFO_DEPTH);

  logic [3:0]         ctrl;
  logic [PRESC_W-1:0] presc;
  logic [PRESC_W-1:0] pcnt;
  logic [CNT_W-1:0]   count;
  logic               overrun;
  logic               wrap;
  logic [CNT_W-1:0]   fifo [FIFO_DEPTH];
  logic [AW:0]        wr_ptr;
  logic [AW:0]        rd_ptr;
  logic               s1, s2, prev;

  logic        access, wr_acc, rd_acc;
  logic [2:0]  idx;
  logic [AW:0] level;
  logic        not_empty, full, en, tick;
  logic        rise, fall, edge_hit, pop, push_ok, overrun_set, wrap_set, cnt_wr;
  logic [31:0] rdata_next;
  logic        unused_addr_bits;

  assign access    = mem_valid & ~mem_ready;
  assign wr_acc    = access & mem_we;
  assign rd_acc    = access & ~mem_we;
  assign idx       = mem_addr[4:2];
  assign unused_addr_bits = &{1'b0, mem_addr[1:0]};

  assign level     = wr_ptr - rd_ptr;
  assign not_empty = (level != '0);
  assign full      = (level == (AW+1)'(FIFO_DEPTH));
  assign en        = ctrl[0];
  assign tick      = en & (pcnt == presc);
  assign cnt_wr    = wr_acc & (idx == 3'd2);

  assign rise      = s2 & ~prev;
  assign fall      = ~s2 & prev;
  assign edge_hit  = en & ((ctrl[1] & rise) | (ctrl[2] & fall));
  assign pop       = rd_acc & (idx == 3'd3) & not_empty;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
  assign push_ok     = edge_hit & (~full | pop);
  assign overrun_set = edge_hit & full & ~pop;
  assign wrap_set    = tick & (count == {CNT_W{1'b1}}) & ~cnt_wr;

  always_comb begin
    rdata_next = '0;
    case (idx)
      3'd0: rdata_next = {28'b0, ctrl};
      3'd1: rdata_next = 32'(presc);
      3'd2: rdata_next = 32'(count);
      3'd3: if (not_empty) rdata_next = 32'(fifo[rd_ptr[AW-1:0]]);
      3'd4: rdata_next = {20'b0, 4'(level), 4'b0, wrap, overrun, full, not_empty};
      default: rdata_next = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push_ok) fifo[wr_ptr[AW-1:0]] <= count;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ctrl      <= '0;
      presc     <= '0;
      pcnt      <= '0;
      count     <= '0;
      overrun   <= 1'b0;
      wrap      <= 1'b0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      s1        <= 1'b0;
      s2        <= 1'b0;
      prev      <= 1'b0;
      mem_ready <= 1'b0;
      mem_rdata <= '0;
      irq       <= 1'b0;
    end else begin
      s1   <= cap_in;
      s2   <= s1;
      prev <= s2;

      mem_ready <= access;
      if (access) mem_rdata <= rdata_next;

      if (wr_acc && idx == 3'd0) ctrl  <= mem_wdata[3:0];
      if (wr_acc && idx == 3'd1) presc <= mem_wdata[PRESC_W-1:0];

      if (wr_acc && idx == 3'd1) pcnt <= '0;
      else if (en)               pcnt <= (pcnt == presc) ? '0 : pcnt + 1'b1;

      // A bus write to COUNT overrides any tick landing in the same cycle.
      if (cnt_wr)    count <= mem_wdata[CNT_W-1:0];
      else if (tick) count <= count + 1'b1;

      if (overrun_set)                                 overrun <= 1'b1;
      else if (wr_acc && idx == 3'd4 && mem_wdata[2])  overrun <= 1'b0;
      if (wrap_set)                                    wrap <= 1'b1;
      else if (wr_acc && idx == 3'd4 && mem_wdata[3])  wrap <= 1'b0;

      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;

      irq <= ctrl[3] & (not_empty | overrun | wrap);
    end
  end
endmodule
